// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions used by the branch-resolution logic: datapath width,
// condition-code bit positions, BR mask shorthands and the BR FSM state encoding.
package lc3b_pkg;

    localparam int WORD_W = 16;

    // Bit positions of the flags inside a {n,z,p} vector, matching IR[11:9].
    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    localparam logic [2:0] NZP_NONE = 3'b000;
    localparam logic [2:0] NZP_ALL  = 3'b111;

    typedef enum logic [1:0] {
        BR_IDLE    = 2'd0,
        BR_WAIT_CC = 2'd1,
        BR_RESOLVE = 2'd2,
        BR_HOLD    = 2'd3
    } br_state_e;

    // Taken is strictly the OR of mask AND flags: nzp=111 with all flags clear is not taken.
    function automatic logic br_taken(input logic [2:0] nzp, input logic [2:0] cc);
        return |(nzp & cc);
    endfunction

endpackage

// File: rtl/br_target_adder.sv
// Branch target arithmetic: pc + (sext(offset) << 1), wrapping modulo 2^WORD_W.
module br_target_adder #(
    parameter int WORD_W = 16,
    parameter int OFF_W  = 9
) (
    input  logic [WORD_W-1:0] pc,
    input  logic [OFF_W-1:0]  offset,
    output logic [WORD_W-1:0] target
);

    logic [WORD_W-1:0] off_sext;

    assign off_sext = {{(WORD_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign target   = pc + (off_sext << 1);

endmodule

// File: rtl/br_condition_unit.sv
// Resolves LC-3b BR instructions against the N/Z/P condition codes, waiting out any
// in-flight setcc write, and holds a registered taken/target result for the PC logic.
module br_condition_unit #(
    parameter int WORD_W  = lc3b_pkg::WORD_W,
    parameter int OFF_W   = 9,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_nzp,
    input  logic [WORD_W-1:0]  req_pc,
    input  logic [OFF_W-1:0]   req_offset,
    input  logic               ccr_n,
    input  logic               ccr_z,
    input  logic               ccr_p,
    input  logic               cc_pending,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_taken,
    output logic [WORD_W-1:0]  rsp_target,
    output logic [STALL_W-1:0] stall_cnt
);

    import lc3b_pkg::*;

    br_state_e         state;
    logic [2:0]        nzp_q;
    logic [WORD_W-1:0] pc_q;
    logic [OFF_W-1:0]  off_q;

    logic [2:0]        cc_flags;
    logic              taken;
    logic [WORD_W-1:0] target_sum;

    always_comb begin
        cc_flags       = '0;
        cc_flags[CC_N] = ccr_n;
        cc_flags[CC_Z] = ccr_z;
        cc_flags[CC_P] = ccr_p;
    end

    assign taken     = br_taken(nzp_q, cc_flags);
    assign req_ready = reset && (state == BR_IDLE);

    br_target_adder #(
        .WORD_W (WORD_W),
        .OFF_W  (OFF_W)
    ) u_target_adder (
        .pc     (pc_q),
        .offset (off_q),
        .target (target_sum)
    );

    // State advances on the falling edge so results line up with the datapath registers.
    // NOTE: all state here uses non-blocking assignments so every register sees the pre-edge values.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BR_IDLE;
            nzp_q      <= '0;
            pc_q       <= '0;
            off_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_taken  <= 1'b0;
            rsp_target <= '0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                BR_IDLE: begin
                    if (req_valid) begin
                        nzp_q <= req_nzp;
                        pc_q  <= req_pc;
                        off_q <= req_offset;
                        state <= cc_pending ? BR_WAIT_CC : BR_RESOLVE;
                    end
                end
                BR_WAIT_CC: begin
                    if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                    if (!cc_pending) begin
                        state <= BR_RESOLVE;
                    end
                end
                BR_RESOLVE: begin
                    rsp_valid  <= 1'b1;
                    rsp_taken  <= taken;
                    rsp_target <= taken ? target_sum : pc_q;
                    state      <= BR_HOLD;
                end
                BR_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= BR_IDLE;
                    end
                end
                default: state <= BR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_br_condition_unit.sv
// Self-checking bench for br_condition_unit: directed vector table, hand-written
// hold/reset/saturation sequences and random requests against a behavioural model.
module tb_br_condition_unit;

    import lc3b_pkg::*;

    localparam int STALL_MAX = 255;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_nzp;
    logic [15:0] req_pc;
    logic [8:0]  req_offset;
    logic        ccr_n, ccr_z, ccr_p;
    logic        cc_pending;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_taken;
    logic [15:0] rsp_target;
    logic [7:0]  stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_stall = 0;

    br_condition_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_nzp    (req_nzp),
        .req_pc     (req_pc),
        .req_offset (req_offset),
        .ccr_n      (ccr_n),
        .ccr_z      (ccr_z),
        .ccr_p      (ccr_p),
        .cc_pending (cc_pending),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_taken  (rsp_taken),
        .rsp_target (rsp_target),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  nzp;
        logic [15:0] pc;
        logic [8:0]  off;
        logic [2:0]  flags;
        logic [2:0]  wait_flags;
        int          d;
        int          hold;
        logic        exp_taken;
        logic [15:0] exp_target;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Active edge is the falling edge; sample half a cycle later on the rising edge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    // Reference: branch semantics straight from the ISA, with integer arithmetic mod 2^16.
    function automatic void model(input logic [2:0] nzp, input logic [15:0] pc, input logic [8:0] off,
                                  input logic [2:0] flags, output logic taken, output logic [15:0] tgt);
        int so;
        int sum;
        so    = off[8] ? int'(off) - 512 : int'(off);
        taken = (nzp[2] && flags[2]) || (nzp[1] && flags[1]) || (nzp[0] && flags[0]);
        sum   = (int'(pc) + 2 * so + 65536) % 65536;
        tgt   = taken ? 16'(sum) : pc;
    endfunction

    task automatic set_flags(input logic [2:0] f);
        {ccr_n, ccr_z, ccr_p} = f;
    endtask

    // One full request: accept, d pending cycles, resolve, hold cycles, then release.
    task automatic run_req(input string tag, input logic [2:0] nzp, input logic [15:0] pc,
                           input logic [8:0] off, input logic [2:0] flags, input logic [2:0] wait_flags,
                           input int d, input int hold, input logic keep_valid,
                           input logic exp_taken, input logic [15:0] exp_target);
        rsp_ready = 1'b0;
        check({tag, ".ready_idle"}, 32'(req_ready), 32'(1));
        req_valid  = 1'b1;
        req_nzp    = nzp;
        req_pc     = pc;
        req_offset = off;
        cc_pending = (d > 0);
        set_flags(wait_flags);
        step();
        check({tag, ".ready_busy"}, 32'(req_ready), 32'(0));
        check({tag, ".early_valid"}, 32'(rsp_valid), 32'(0));
        req_valid  = 1'b0;
        req_nzp    = 3'($urandom);
        req_pc     = 16'($urandom);
        req_offset = 9'($urandom);
        for (int i = 1; i <= d; i++) begin
            cc_pending = (i < d);
            set_flags(wait_flags);
            step();
            check({tag, ".wait_valid"}, 32'(rsp_valid), 32'(0));
        end
        set_flags(flags);
        cc_pending = 1'($urandom);
        step();
        exp_stall = (exp_stall + d > STALL_MAX) ? STALL_MAX : exp_stall + d;
        check({tag, ".valid"}, 32'(rsp_valid), 32'(1));
        check({tag, ".taken"}, 32'(rsp_taken), 32'(exp_taken));
        check({tag, ".target"}, 32'(rsp_target), 32'(exp_target));
        check({tag, ".stall"}, 32'(stall_cnt), 32'(exp_stall));
        for (int i = 0; i < hold; i++) begin
            req_valid  = keep_valid;
            req_nzp    = 3'($urandom);
            req_pc     = 16'($urandom);
            set_flags(3'($urandom));
            cc_pending = 1'($urandom);
            step();
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'(1));
            check({tag, ".hold_taken"}, 32'(rsp_taken), 32'(exp_taken));
            check({tag, ".hold_target"}, 32'(rsp_target), 32'(exp_target));
            check({tag, ".hold_ready"}, 32'(req_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".released"}, 32'(rsp_valid), 32'(0));
        check({tag, ".back_idle"}, 32'(req_ready), 32'(1));
        req_valid = keep_valid;
    endtask

    initial begin
        logic        m_taken;
        logic [15:0] m_tgt;
        logic [2:0]  r_nzp, r_flags;
        logic [15:0] r_pc;
        logic [8:0]  r_off;

        vecs[0] = '{3'b010,   16'h3002, 9'h004, 3'b010, 3'b000, 0, 0, 1'b1, 16'h300A};
        vecs[1] = '{3'b101,   16'h3002, 9'h004, 3'b010, 3'b000, 0, 1, 1'b0, 16'h3002};
        vecs[2] = '{3'b001,   16'h4000, 9'h010, 3'b001, 3'b100, 3, 0, 1'b1, 16'h4020};
        vecs[3] = '{NZP_ALL,  16'h0000, 9'h1FF, 3'b100, 3'b000, 0, 0, 1'b1, 16'hFFFE};
        vecs[4] = '{NZP_ALL,  16'hFFFE, 9'h001, 3'b001, 3'b000, 1, 0, 1'b1, 16'h0000};
        vecs[5] = '{NZP_NONE, 16'h1234, 9'h000, 3'b111, 3'b111, 0, 2, 1'b0, 16'h1234};
        vecs[6] = '{NZP_ALL,  16'h1000, 9'h100, 3'b000, 3'b111, 2, 0, 1'b0, 16'h1000};
        vecs[7] = '{3'b010,   16'h2000, 9'h0FF, 3'b110, 3'b000, 0, 0, 1'b1, 16'h21FE};
        vecs[8] = '{3'b100,   16'h8000, 9'h100, 3'b111, 3'b000, 2, 0, 1'b1, 16'h7E00};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_nzp    = '0;
        req_pc     = '0;
        req_offset = '0;
        set_flags(3'b000);
        cc_pending = 1'b0;
        rsp_ready  = 1'b0;
        #2;
        check("rst.valid", 32'(rsp_valid), 32'(0));
        check("rst.taken", 32'(rsp_taken), 32'(0));
        check("rst.target", 32'(rsp_target), 32'(0));
        check("rst.stall", 32'(stall_cnt), 32'(0));
        check("rst.ready", 32'(req_ready), 32'(0));
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("rst.ready_release", 32'(req_ready), 32'(1));
        step();

        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].nzp, vecs[i].pc, vecs[i].off, vecs[i].flags,
                    vecs[i].wait_flags, vecs[i].d, vecs[i].hold, 1'b0,
                    vecs[i].exp_taken, vecs[i].exp_target);
        end

        // Held request during a stalled consumer is only taken after HOLD returns to IDLE.
        run_req("hold1", 3'b010, 16'h3002, 9'h004, 3'b010, 3'b000, 0, 4, 1'b1, 1'b1, 16'h300A);
        run_req("hold2", 3'b100, 16'h5000, 9'h002, 3'b100, 3'b000, 0, 0, 1'b0, 1'b1, 16'h5004);

        // Reset in WAIT_CC with stall_cnt at 5 drops the request immediately.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        exp_stall = 0;
        step();
        run_req("pre6", 3'b001, 16'h6000, 9'h003, 3'b001, 3'b000, 2, 0, 1'b0, 1'b1, 16'h6006);
        req_valid  = 1'b1;
        req_nzp    = 3'b111;
        req_pc     = 16'h7000;
        req_offset = 9'h005;
        cc_pending = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("r6.stall5", 32'(stall_cnt), 32'(5));
        reset = 1'b0;
        #1;
        check("r6.valid", 32'(rsp_valid), 32'(0));
        check("r6.taken", 32'(rsp_taken), 32'(0));
        check("r6.target", 32'(rsp_target), 32'(0));
        check("r6.stall", 32'(stall_cnt), 32'(0));
        check("r6.ready", 32'(req_ready), 32'(0));
        #1;
        reset      = 1'b1;
        cc_pending = 1'b0;
        exp_stall  = 0;
        #1;
        check("r6.idle", 32'(req_ready), 32'(1));
        step();
        run_req("post6", 3'b010, 16'h3002, 9'h004, 3'b010, 3'b000, 1, 0, 1'b0, 1'b1, 16'h300A);

        // Long stall drives the counter into saturation.
        run_req("sat", 3'b001, 16'h0100, 9'h0F0, 3'b001, 3'b110, 300, 0, 1'b0, 1'b1, 16'h02E0);

        for (int i = 0; i < 40; i++) begin
            r_nzp   = 3'($urandom);
            r_pc    = 16'($urandom);
            r_off   = 9'($urandom);
            r_flags = 3'($urandom);
            model(r_nzp, r_pc, r_off, r_flags, m_taken, m_tgt);
            run_req($sformatf("rnd%0d", i), r_nzp, r_pc, r_off, r_flags, 3'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, m_taken, m_tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
